// File: rtl/usb_token_tx.sv
// USB full/low-speed token packet transmitter: SYNC, PID, 16-bit token payload with CRC5,
// NRZI encoding with bit stuffing, and EOP, oversampled BIT_SAMPLES clocks per bit.
module usb_token_tx #(
    parameter int BIT_SAMPLES = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [3:0]  pid_i,
    input  logic [6:0]  addr_i,
    input  logic [3:0]  endp_i,
    input  logic [10:0] frame_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        tx_en_o,
    output logic        tx_dp_o,
    output logic        tx_dn_o
);

    localparam int CNT_W = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_PAYLOAD,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t            state_q;
    state_t            nxt_state;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        idx_q;
    logic [3:0]        nxt_idx;
    logic [2:0]        ones_q;
    logic [3:0]        pid_q;
    logic [10:0]       pay_q;
    logic [4:0]        crc_q;
    logic              lvl_q;
    logic              nxt_bit;
    logic              nxt_is_crc;
    logic              tick;
    logic              stuff;
    logic              accept;
    logic [7:0]        pid_byte;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
        logic fb;
        fb = c[4] ^ d;
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    // All four token PIDs share the low bits 2'b01.
    assign accept   = start_i && !busy_o && (pid_i[1:0] == 2'b01);
    assign tick     = (cnt_q == CNT_MAX);
    assign pid_byte = {~pid_q, pid_q};
    assign stuff    = (ones_q == 3'd6) &&
                      ((state_q == S_SYNC) || (state_q == S_PID) || (state_q == S_PAYLOAD));

    always_comb begin
        nxt_state  = state_q;
        nxt_idx    = idx_q + 4'd1;
        nxt_bit    = 1'b0;
        nxt_is_crc = 1'b0;
        case (state_q)
            S_SYNC:    if (idx_q == 4'd7)  begin nxt_state = S_PID;     nxt_idx = 4'd0; end
            S_PID:     if (idx_q == 4'd7)  begin nxt_state = S_PAYLOAD; nxt_idx = 4'd0; end
            S_PAYLOAD: if (idx_q == 4'd15) begin nxt_state = S_EOP_SE0; nxt_idx = 4'd0; end
            S_EOP_SE0: if (idx_q == 4'd1)  begin nxt_state = S_EOP_J;   nxt_idx = 4'd0; end
            default:   begin nxt_state = S_IDLE; nxt_idx = 4'd0; end
        endcase
        case (nxt_state)
            S_SYNC: nxt_bit = (nxt_idx == 4'd7);
            S_PID:  nxt_bit = pid_byte[nxt_idx[2:0]];
            S_PAYLOAD: begin
                if (nxt_idx < 4'd11) begin
                    nxt_bit = pay_q[nxt_idx];
                end else begin
                    nxt_is_crc = 1'b1;
                    nxt_bit    = ~crc_q[4];
                end
            end
            default: nxt_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            pid_q   <= '0;
            pay_q   <= '0;
            crc_q   <= '0;
            lvl_q   <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            tx_en_o <= 1'b0;
            tx_dp_o <= 1'b1;
            tx_dn_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q == S_IDLE) begin
                busy_o <= 1'b0;
                if (accept) begin
                    pid_q   <= pid_i;
                    pay_q   <= (pid_i == 4'b0101) ? frame_i : {endp_i, addr_i};
                    crc_q   <= 5'b11111;
                    state_q <= S_SYNC;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    ones_q  <= '0;
                    // First SYNC bit is a 0: line moves from idle J to K.
                    lvl_q   <= 1'b0;
                    tx_dp_o <= 1'b0;
                    tx_dn_o <= 1'b1;
                    tx_en_o <= 1'b1;
                    busy_o  <= 1'b1;
                end
            end else begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    if (stuff) begin
                        lvl_q   <= ~lvl_q;
                        tx_dp_o <= ~lvl_q;
                        tx_dn_o <= lvl_q;
                        ones_q  <= '0;
                    end else begin
                        state_q <= nxt_state;
                        idx_q   <= nxt_idx;
                        case (nxt_state)
                            S_SYNC, S_PID, S_PAYLOAD: begin
                                if (!nxt_bit) begin
                                    lvl_q   <= ~lvl_q;
                                    tx_dp_o <= ~lvl_q;
                                    tx_dn_o <= lvl_q;
                                    ones_q  <= '0;
                                end else begin
                                    tx_dp_o <= lvl_q;
                                    tx_dn_o <= ~lvl_q;
                                    ones_q  <= ones_q + 3'd1;
                                end
                                // CRC absorbs data bits, then shifts its own bits out MSB first.
                                if (nxt_state == S_PAYLOAD)
                                    crc_q <= nxt_is_crc ? {crc_q[3:0], 1'b0}
                                                        : crc5_step(crc_q, nxt_bit);
                            end
                            S_EOP_SE0: begin
                                tx_dp_o <= 1'b0;
                                tx_dn_o <= 1'b0;
                            end
                            S_EOP_J: begin
                                lvl_q   <= 1'b1;
                                tx_dp_o <= 1'b1;
                                tx_dn_o <= 1'b0;
                            end
                            default: begin
                                lvl_q   <= 1'b1;
                                tx_dp_o <= 1'b1;
                                tx_dn_o <= 1'b0;
                                tx_en_o <= 1'b0;
                                done_o  <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/usb_token_tx.md
USB_TOKEN_TX -- requirements
Module: usb_token_tx

Interface
REQ-001 SHALL have parameter BIT_SAMPLES, default 4, meaning clk_i cycles per USB bit time (clk_i = 12 MHz*BIT_SAMPLES).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to send one token packet.
REQ-005 SHALL have port pid_i  input  4  token PID: OUT 4'b0001, IN 4'b1001, SOF 4'b0101, SETUP 4'b1101.
REQ-006 SHALL have port addr_i  input  7  device address (OUT/IN/SETUP).
REQ-007 SHALL have port endp_i  input  4  endpoint number (OUT/IN/SETUP).
REQ-008 SHALL have port frame_i  input  11  frame number (SOF).
REQ-009 SHALL have port busy_o  output  1  high from start acceptance until done_o cycle inclusive.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse at packet end.
REQ-011 SHALL have ports tx_en_o, tx_dp_o, tx_dn_o  output  1 each  line driver enable and D+/D- levels.

Function
REQ-012 start_i SHALL be accepted only when busy_o=0 and pid_i is one of the four token PIDs; other PIDs, or start_i while busy, SHALL be ignored (no transmission, no done_o).
REQ-013 On acceptance all inputs SHALL be latched; later input changes SHALL not affect the packet.
REQ-014 tx_en_o SHALL rise in the cycle after acceptance; each line state SHALL be held exactly BIT_SAMPLES clk_i cycles.
REQ-015 Bit stream, each field LSB first: SYNC 8'b10000000 (seven 0s then 1), PID byte {~pid, pid}, 16-bit payload.
REQ-016 Payload: SOF = frame[10:0] then CRC5; others = addr[6:0], endp[3:0], then CRC5.
REQ-017 CRC5: polynomial x^5+x^2+1, register preset 5'b11111, over the 11 payload bits in transmit order, inverted result sent MSB (bit 4) first.
REQ-018 NRZI: data 0 toggles line between J (dp=1,dn=0) and K (dp=0,dn=1); data 1 holds; line before SYNC is J.
REQ-019 Bit stuffing: after six consecutive transmitted 1s (count starts at SYNC) a 0 SHALL be inserted; the counter SHALL clear on any 0, stuffed or data; stuffing after the final payload bit SHALL also occur.
REQ-020 EOP: two bit times SE0 (dp=0,dn=0), then one bit time J, then tx_en_o low with line J.
REQ-021 State machine: IDLE -> SYNC (8 bits) -> PID (8 bits) -> PAYLOAD (16 bits, stuffing inserted) -> EOP_SE0 (2 bits) -> EOP_J (1 bit) -> IDLE.
REQ-022 done_o SHALL pulse in the cycle tx_en_o falls; busy_o SHALL drop the following cycle; a start_i in that following cycle SHALL be accepted.
REQ-023 Packet length SHALL be (35 + stuffed bits) * BIT_SAMPLES cycles with tx_en_o high.
REQ-024 Bit-time counter SHALL be ceil(log2(BIT_SAMPLES)) bits and wrap to 0 at BIT_SAMPLES-1.

Reset
REQ-025 While rstn_i=0: tx_en_o=0, tx_dp_o=1, tx_dn_o=0, busy_o=0, done_o=0, state IDLE, counters and CRC cleared, asynchronously.
REQ-026 Reset asserted mid-packet SHALL abort immediately without EOP and without done_o; first start after release SHALL send a complete packet.

Verification
REQ-027 SETUP addr=0x00 endp=0x0 -> CRC5 5'b01000 sent as bits 0,1,0,0,0... equivalent to payload CRC field 0x02 per USB 2.0 examples; decoded PID byte 0x2D; 35 bit times, no stuffing.
REQ-028 OUT addr=0x3A endp=0xA -> decoded PID 0xE1, CRC5 0x1C; tx_en_o high exactly 35*BIT_SAMPLES cycles plus stuffed bits from a reference decoder.
REQ-029 SOF frame=0x7FF -> decoded PID 0xA5, payload 11 ones forces stuffed 0 after sixth and twelfth consecutive 1; decoder after unstuffing recovers frame 0x7FF with CRC check passing.
REQ-030 start_i with pid_i=4'b0011, and start_i while busy -> no tx_en_o change, no done_o, in-flight packet bit-exact.
REQ-031 rstn_i low during PAYLOAD -> same cycle tx_en_o=0, line J, no done_o; IN addr=0x01 endp=0x1 after release -> complete valid packet, PID 0x69, done_o single pulse.
